demux1_2_stream: RTL and testbench

//   Registered 1-to-2 demultiplexer for a valid/ready byte stream.

---
 rtl/demux1_2_stream.sv | 166 ++++++++++++++++
 tb/tb_demux1_2_stream.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/demux1_2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with one-deep holding
// register per output channel, steered or de-interleave routing, and beat counters.

// One-deep holding register for a single output channel.
module demux1_2_stream_hold #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    // NOTE: the payload register is reset too, so the output reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            // A load wins over a drain: valid stays high with the new beat.
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// Saturating beat counter with synchronous clear that wins over increment.
module demux1_2_stream_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

module demux1_2_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              in_ready,
    output logic              out1_valid,
    output logic [DATA_W-1:0] out1_data,
    input  logic              out1_ready,
    output logic              out2_valid,
    output logic [DATA_W-1:0] out2_data,
    input  logic              out2_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2
);

    typedef enum logic {
        CH1 = 1'b0,
        CH2 = 1'b1
    } chan_e;

    logic  mode_q;
    logic  phase_q;
    logic  mode_rise;
    logic  phase_eff;
    chan_e tgt;
    logic  accept;
    logic  load1;
    logic  load2;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        mode_rise = 1'b0;
        phase_eff = 1'b0;
        tgt       = CH1;
        in_ready  = 1'b0;
        accept    = 1'b0;
        load1     = 1'b0;
        load2     = 1'b0;

        // The first beat after entering de-interleave mode always goes to out1.
        mode_rise = mode & ~mode_q;
        phase_eff = mode_rise ? 1'b0 : phase_q;
        tgt       = chan_e'(mode ? phase_eff : in_sel);

        in_ready  = (tgt == CH1) ? (~out1_valid | out1_ready)
                                 : (~out2_valid | out2_ready);
        accept    = in_valid & in_ready;
        load1     = accept & (tgt == CH1);
        load2     = accept & (tgt == CH2);
    end

    // Phase only advances in de-interleave mode and is frozen while steered.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q  <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            mode_q <= mode;
            if (mode) begin
                phase_q <= phase_eff ^ accept;
            end
        end
    end

    demux1_2_stream_hold #(.DATA_W(DATA_W)) u_hold1 (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .load      (load1),
        .load_data (in_data),
        .ready     (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data)
    );

    demux1_2_stream_hold #(.DATA_W(DATA_W)) u_hold2 (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .load      (load2),
        .load_data (in_data),
        .ready     (out2_ready),
        .valid     (out2_valid),
        .data      (out2_data)
    );

    demux1_2_stream_cnt #(.CNT_W(CNT_W)) u_cnt1 (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (cnt_clr),
        .inc   (load1),
        .cnt   (cnt1)
    );

    demux1_2_stream_cnt #(.CNT_W(CNT_W)) u_cnt2 (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (cnt_clr),
        .inc   (load2),
        .cnt   (cnt2)
    );

endmodule

// File: tb/tb_demux1_2_stream.sv
// Scoreboard bench for demux1_2_stream: directed scenarios plus random traffic,
// checked against per-channel expected-beat queues and a beat-count model.
module tb_demux1_2_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              mode;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_ready;
    logic              out1_valid;
    logic [DATA_W-1:0] out1_data;
    logic              out1_ready;
    logic              out2_valid;
    logic [DATA_W-1:0] out2_data;
    logic              out2_ready;
    logic              cnt_clr;
    logic [CNT_W-1:0]  cnt1;
    logic [CNT_W-1:0]  cnt2;

    demux1_2_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .out2_valid (out2_valid),
        .out2_data  (out2_data),
        .out2_ready (out2_ready),
        .cnt_clr    (cnt_clr),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: beats awaiting delivery per channel, accepted-beat
    // counts, and how many beats were accepted since de-interleave mode began.
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] q2[$];
    int  exp_cnt1 = 0;
    int  exp_cnt2 = 0;
    int  alt_beats = 0;
    logic prev_mode = 1'b0;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            check("rst_out1_valid", 32'(out1_valid), 32'd0);
            check("rst_out2_valid", 32'(out2_valid), 32'd0);
            check("rst_out1_data",  32'(out1_data),  32'd0);
            check("rst_out2_data",  32'(out2_data),  32'd0);
            check("rst_cnt1",       32'(cnt1),       32'd0);
            check("rst_cnt2",       32'(cnt2),       32'd0);
            q1.delete();
            q2.delete();
            exp_cnt1  = 0;
            exp_cnt2  = 0;
            alt_beats = 0;
            prev_mode = 1'b0;
        end else begin
            int  to_ch2;
            logic exp_ready;
            logic acc;

            if (mode && !prev_mode) alt_beats = 0;
            to_ch2    = mode ? (alt_beats % 2) : int'(in_sel);
            exp_ready = (to_ch2 != 0) ? (q2.size() == 0 || out2_ready)
                                      : (q1.size() == 0 || out1_ready);

            check("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
            check("out2_valid", 32'(out2_valid), 32'(q2.size() != 0));
            check("in_ready",   32'(in_ready),   32'(exp_ready));
            check("cnt1",       32'(cnt1),       32'(exp_cnt1));
            check("cnt2",       32'(cnt2),       32'(exp_cnt2));

            if (out1_valid && q1.size() != 0) begin
                check("out1_data", 32'(out1_data), 32'(q1[0]));
                if (out1_ready) void'(q1.pop_front());
            end
            if (out2_valid && q2.size() != 0) begin
                check("out2_data", 32'(out2_data), 32'(q2[0]));
                if (out2_ready) void'(q2.pop_front());
            end

            acc = in_valid & in_ready;
            if (acc) begin
                if (to_ch2 != 0) q2.push_back(in_data);
                else             q1.push_back(in_data);
                if (mode) alt_beats++;
            end
            if (cnt_clr) begin
                exp_cnt1 = 0;
                exp_cnt2 = 0;
            end else if (acc) begin
                if (to_ch2 != 0) exp_cnt2 = (exp_cnt2 < CNT_MAX) ? exp_cnt2 + 1 : CNT_MAX;
                else             exp_cnt1 = (exp_cnt1 < CNT_MAX) ? exp_cnt1 + 1 : CNT_MAX;
            end
            prev_mode = mode;
        end
    end

    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic s);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        mode       = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        cnt_clr    = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        cyc(0, 8'h00, 0);

        // Steered routing, back-to-back beats.
        cyc(1, 8'hA5, 0);
        cyc(1, 8'h3C, 1);
        check("seq1_out1_a5", 32'(out1_data), 32'hA5);
        cyc(1, 8'h7E, 0);
        check("seq1_out2_3c", 32'(out2_data), 32'h3C);
        cyc(0, 8'h00, 0);
        check("seq1_out1_7e", 32'(out1_data), 32'h7E);
        check("seq1_cnt1", 32'(cnt1), 32'd2);
        check("seq1_cnt2", 32'(cnt2), 32'd1);

        // Back-pressure on out1, then load in the drain cycle.
        out1_ready = 1'b0;
        cyc(1, 8'h11, 0);
        repeat (3) cyc(1, 8'h22, 0);
        check("seq2_held_11", 32'(out1_data), 32'h11);
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'h22;
        #1 check("seq2_no_bubble", 32'(in_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        check("seq2_out1_22", 32'(out1_data), 32'h22);
        cyc(0, 8'h00, 0);

        // De-interleave, in_sel random.
        mode = 1'b1;
        for (int i = 1; i <= 6; i++) cyc(1, DATA_W'(i), 1'($urandom));
        cyc(0, 8'h00, 0);

        // Reset while out2 holds a beat mid-sequence.
        out2_ready = 1'b0;
        cyc(1, 8'h40, 1'($urandom));
        cyc(1, 8'h41, 1'($urandom));
        check("seq4_out2_held", 32'(out2_valid), 32'd1);
        sys_rst_n = 1'b0;
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        sys_rst_n = 1'b1;
        cyc(1, 8'h50, 1'($urandom));
        check("seq4_first_to_out1", 32'(out1_valid), 32'd1);
        check("seq4_first_data",    32'(out1_data),  32'h50);
        check("seq4_out2_empty",    32'(out2_valid), 32'd0);
        out2_ready = 1'b1;
        cyc(0, 8'h00, 0);

        // Counter saturation and clear-wins-over-accept.
        mode = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) cyc(1, DATA_W'($urandom), 0);
        cyc(0, 8'h00, 0);
        check("seq5_cnt1_sat", 32'(cnt1), 32'(CNT_MAX));
        cnt_clr = 1'b1;
        cyc(1, 8'h99, 0);
        cnt_clr = 1'b0;
        check("seq5_clr_wins", 32'(cnt1), 32'd0);
        cyc(0, 8'h00, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(31) == 0) mode = ~mode;
            out1_ready = ($urandom_range(9) < 7);
            out2_ready = ($urandom_range(9) < 6);
            cnt_clr    = ($urandom_range(39) == 0);
            cyc(1'($urandom_range(3) != 0), DATA_W'($urandom), 1'($urandom));
        end
        cnt_clr    = 1'b0;
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        repeat (3) cyc(0, 8'h00, 0);
        check("drain_q1_empty", 32'(q1.size()), 32'd0);
        check("drain_q2_empty", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
